sata_crc_unit: RTL

Parametrised SerialATA frame CRC engine on the 32-bit dword stream between the transport and link layers. MODE_CHECK=0 (transmit): passes frame dwords through and appends the running CRC as an extra final dword. MODE_CHECK=1 (receive): strips the trailing CRC dword, compares it with the computed value, and flags the result on the last data dword. It also keeps a saturating count of bad frames for the status registers.

---
 rtl/sata_crc_pkg.sv | 13 +
 rtl/sata_crc_unit_crc.sv | 30 +++
 rtl/sata_crc_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sata_crc_pkg.sv
// SATA frame CRC shared definitions.
// Default polynomial/seed and generate-mode states.
package sata_crc_pkg;

  localparam logic [31:0] CRC_POLYNOMIAL = 32'h04C11DB7;
  localparam logic [31:0] CRC_INITVALUE  = 32'h52325032;

  typedef enum logic {
    PASS,
    APPEND
  } gen_state_e;

endpackage

// File: rtl/sata_crc_unit_crc.sv
// Combinational MSB-first CRC step over one data word.
// No reflection and no final XOR.
module crc_calculator
  import sata_crc_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int CRCWIDTH  = 32,
  parameter logic [CRCWIDTH-1:0] POLYNOMIAL =
    CRCWIDTH'(CRC_POLYNOMIAL)
) (
  input  logic [DATAWIDTH-1:0] i_data,
  input  logic [CRCWIDTH-1:0]  i_crc,
  output logic [CRCWIDTH-1:0]  o_crc
);

  logic [CRCWIDTH-1:0] c;
  logic                fb;

  always_comb begin
    c  = i_crc;
    fb = 1'b0;
    for (int i = DATAWIDTH - 1; i >= 0; i--) begin
      fb = c[CRCWIDTH-1] ^ i_data[i];
      c  = {c[CRCWIDTH-2:0], 1'b0};
      if (fb) c = c ^ POLYNOMIAL;
    end
    o_crc = c;
  end

endmodule

// File: rtl/sata_crc_unit.sv
// SATA frame CRC engine: appends CRC (generate) or
// strips and verifies it (check) on a dword stream.
module sata_crc_unit
  import sata_crc_pkg::*;
#(
  parameter int          MODE_CHECK  = 0,
  parameter logic [31:0] POLYNOMIAL  = CRC_POLYNOMIAL,
  parameter logic [31:0] INITVALUE   = CRC_INITVALUE,
  parameter int          ERRCNTWIDTH = 16
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic [31:0]            i_dat,
  input  logic                   i_val,
  input  logic                   i_eop,
  output logic                   i_rdy,
  output logic [31:0]            o_dat,
  output logic                   o_val,
  output logic                   o_eop,
  output logic                   o_err,
  input  logic                   o_rdy,
  output logic [ERRCNTWIDTH-1:0] err_cnt,
  input  logic                   err_clr
);

  if (MODE_CHECK == 0) begin : g_gen

    gen_state_e  state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_new;
    logic        unused_gen;

    crc_calculator #(
      .DATAWIDTH (32),
      .CRCWIDTH  (32),
      .POLYNOMIAL(POLYNOMIAL)
    ) u_crc (
      .i_data(i_dat),
      .i_crc (crc_q),
      .o_crc (crc_new)
    );

    always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      unique case (state_q)
        PASS: begin
          if (i_val && o_rdy) begin
            crc_d = crc_new;
            if (i_eop) state_d = APPEND;
          end
        end
        APPEND: begin
          if (o_rdy) begin
            crc_d   = INITVALUE;
            state_d = PASS;
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= PASS;
        crc_q   <= INITVALUE;
      end else begin
        state_q <= state_d;
        crc_q   <= crc_d;
      end
    end

    assign i_rdy      = (state_q == PASS) & o_rdy;
    assign o_val      = (state_q == APPEND) | i_val;
    assign o_dat      = (state_q == APPEND) ? crc_q : i_dat;
    assign o_eop      = (state_q == APPEND);
    assign o_err      = 1'b0;
    assign err_cnt    = '0;
    assign unused_gen = err_clr;

  end else begin : g_chk

    logic [31:0]            hold_dat_q, hold_dat_d;
    logic                   hold_val_q, hold_val_d;
    logic [31:0]            crc_q, crc_d;
    logic [31:0]            crc_new;
    logic [ERRCNTWIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                   in_xfer;
    logic                   crc_bad;
    logic                   bump;

    // CRC runs over the held word, so the trailing
    // CRC dword is compared before it is ever stored.
    crc_calculator #(
      .DATAWIDTH (32),
      .CRCWIDTH  (32),
      .POLYNOMIAL(POLYNOMIAL)
    ) u_crc (
      .i_data(hold_dat_q),
      .i_crc (crc_q),
      .o_crc (crc_new)
    );

    assign i_rdy   = ~hold_val_q | o_rdy;
    assign in_xfer = i_val & i_rdy;
    assign crc_bad = crc_new != i_dat;

    assign o_val   = hold_val_q & i_val;
    assign o_dat   = hold_dat_q;
    assign o_eop   = o_val & i_eop;
    assign o_err   = o_eop & crc_bad;
    assign err_cnt = err_cnt_q;

    always_comb begin
      hold_dat_d = hold_dat_q;
      hold_val_d = hold_val_q;
      crc_d      = crc_q;
      bump       = 1'b0;
      if (in_xfer) begin
        unique case (1'b1)
          hold_val_q & ~i_eop: begin
            crc_d      = crc_new;
            hold_dat_d = i_dat;
          end
          hold_val_q & i_eop: begin
            hold_val_d = 1'b0;
            crc_d      = INITVALUE;
            bump       = crc_bad;
          end
          ~hold_val_q & ~i_eop: begin
            hold_dat_d = i_dat;
            hold_val_d = 1'b1;
          end
          ~hold_val_q & i_eop: begin
            crc_d = INITVALUE;
            bump  = 1'b1;
          end
        endcase
      end
    end

    always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
        err_cnt_d = '0;
      end else if (bump && !(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + ERRCNTWIDTH'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_dat_q <= '0;
        hold_val_q <= 1'b0;
        crc_q      <= INITVALUE;
        err_cnt_q  <= '0;
      end else begin
        hold_dat_q <= hold_dat_d;
        hold_val_q <= hold_val_d;
        crc_q      <= crc_d;
        err_cnt_q  <= err_cnt_d;
      end
    end

  end

endmodule
